jk_sync_counter: RTL and testbench
==================================

# jk_sync_counter

Synchronous modulo-N up/down counter whose state bits are JK flip-flop stages. Each stage's J/K excitation is derived from the next-state value. It sits directly downstream of the JK flip-flop cell: it instantiates WIDTH JK stages and consumes their q outputs to form a count. It provides load, enable, direction, terminal-count and carry-out for timers and dividers in the design.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (2..8)
- MODULO, 10, count range 0..MODULO-1; legal range 2..2^WIDTH

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset); one clock domain only
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous parallel load; priority over en
- din  input  WIDTH  load value
- q  output  WIDTH  current count
- qbar  output  WIDTH  bitwise complement of q
- tc  output  1  terminal count, combinational
- co  output  1  registered carry/borrow pulse

## Operation
- State is held in WIDTH JK stages q[i]. Each stage's J/K is computed from the next-state vector n:
  - j[i] = n[i] & ~q[i]
  - k[i] = ~n[i] & q[i]
  - When n[i] == q[i], the stage sees J=K=0 and holds.
- Next-state n, by priority:
  - rst = 0: q = 0, asynchronously. Overrides everything, including mid-count and mid-load.
  - load = 1: n = din if din < MODULO, else n = MODULO-1 (clamp). en and up are ignored.
  - en = 1, up = 1: n = 0 if q == MODULO-1, else q+1.
  - en = 1, up = 0: n = MODULO-1 if q == 0, else q-1.
  - otherwise: n = q (hold).
- Arithmetic is modulo MODULO. q never leaves 0..MODULO-1 after reset.
- tc = en & ~load & (up ? q == MODULO-1 : q == 0).
- co is registered. It goes to 1 on the clock edge where a wrap occurs (MODULO-1→0 up, or 0→MODULO-1 down). It returns to 0 on the next edge unless another wrap occurs.
- A load never asserts co, including a load to 0 or to MODULO-1.
- When MODULO == 2^WIDTH, the wrap is natural binary overflow. The behaviour is identical to the rules above.

## Timing
- Reset values: q = 0, qbar = all ones, co = 0, tc = en & ~load & ~up.
- rst assertion clears q, qbar and co immediately, with no clock needed.
- On rst deassertion, the first counting edge is the first rising clk edge with rst = 1.
- Latency:
  - load, en and up are sampled on the rising edge; q reflects them 1 cycle later.
  - co follows the wrap on that same edge, so it is coincident with q showing the wrapped value.
  - tc is combinational from the current q, en, load and up. It is valid in the cycle before the wrap edge.
- Direction change takes effect on the same edge it is sampled. No turnaround cycle.
- Simultaneous events:
  - load and en both high: load wins, no count, co = 0.
  - Reset during load: reset wins.
- With en held high, co pulses once every MODULO cycles and is 1 cycle wide. With MODULO == 2, co is high every other cycle.

## Test plan
(WIDTH=4, MODULO=10 unless stated.)
- Reset: drive rst = 0 mid-count at q = 7, between clock edges. Required: q = 0, qbar = 4'hF and co = 0 immediately; q stays 0 until the first edge after rst = 1.
- Up count: en = 1, up = 1 for 12 cycles from 0. Required: q = 1..9, 0, 1, 2; tc = 1 only while q = 9; co = 1 only in the cycle q shows 0 after 9.
- Down count: from q = 2 with en = 1, up = 0. Required: q = 1, 0, 9, 8; tc = 1 while q = 0; co pulses as q becomes 9.
- Load: load = 1, din = 6 with en = 1. Required: q = 6 next cycle, co = 0. Then din = 13. Required: q = 9 (clamped).
- Hold and direction flip: en = 0 for 3 cycles, then up toggled each cycle with en = 1 from q = 5. Required: q holds at 5, then 6, 5, 6, 5; co stays 0.
- Power-of-two: WIDTH = 3, MODULO = 8, en = 1, up = 1. Required: q = 0..7, 0; co pulses once per 8 cycles; J/K excitation is correct for every transition, checked against the rule above.

Source files
------------

// File: rtl/jk_sync_counter.sv
// Modulo-N synchronous up/down counter built from JK flip-flop stages.
// Each stage receives J/K excitation derived from the counter's next-state vector.

module jk_sync_counter_jkff (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic j_i,
    input  logic k_i,
    output logic q_o
);

    logic state_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= 1'b0;
        end else begin
            unique case ({j_i, k_i})
                2'b00:   state_q <= state_q;
                2'b01:   state_q <= 1'b0;
                2'b10:   state_q <= 1'b1;
                default: state_q <= ~state_q;
            endcase
        end
    end

    assign q_o = state_q;

endmodule

module jk_sync_counter #(
    parameter int WIDTH  = 4,
    parameter int MODULO = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             co
);

    if (WIDTH < 2 || WIDTH > 8 || MODULO < 2 || MODULO > (1 << WIDTH)) begin : g_bad_params
        $error("jk_sync_counter: illegal WIDTH/MODULO combination");
    end

    // One extra bit so MODULO == 2**WIDTH is representable for the load clamp.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;
    logic             at_max;
    logic             at_zero;
    logic             co_q;
    logic             co_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        jk_sync_counter_jkff u_stage (
            .clk_i   (clk),
            .rst_n_i (rst),
            .j_i     (j_vec[i]),
            .k_i     (k_vec[i]),
            .q_o     (count_q[i])
        );
    end

    assign at_max  = (count_q == MAX_VAL);
    assign at_zero = (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = ({1'b0, din} < MOD_EXT) ? din : MAX_VAL;
        end else if (en) begin
            if (up) begin
                count_d = at_max ? '0 : count_q + WIDTH'(1);
            end else begin
                count_d = at_zero ? MAX_VAL : count_q - WIDTH'(1);
            end
        end
    end

    // Set only bits that must rise, clear only bits that must fall; others hold.
    assign j_vec = count_d & ~count_q;
    assign k_vec = ~count_d & count_q;

    assign tc   = en & ~load & (up ? at_max : at_zero);
    assign co_d = tc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            co_q <= 1'b0;
        end else begin
            co_q <= co_d;
        end
    end

    assign q    = count_q;
    assign qbar = ~count_q;
    assign co   = co_q;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Scoreboard bench: two counter configurations (4-bit mod 10, 3-bit mod 8)
// driven with shared directed and random stimulus, checked against an arithmetic model.
`timescale 1ns/1ps

module tb_jk_sync_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] din4;
    logic [2:0] din3;
    logic [3:0] q4, qbar4;
    logic [2:0] q3, qbar3;
    logic       tc4, co4, tc3, co3;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit tc;
        int qnow;
        int conow;
        int qnext;
        int conext;
        int jexp;
        int kexp;
    } exp_t;

    exp_t sb4[$];
    exp_t sb3[$];

    int m4q = 0, m4co = 0, m3q = 0, m3co = 0;

    jk_sync_counter #(.WIDTH(4), .MODULO(10)) u4 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din4),
        .q(q4), .qbar(qbar4), .tc(tc4), .co(co4)
    );

    jk_sync_counter #(.WIDTH(3), .MODULO(8)) u3 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din3),
        .q(q3), .qbar(qbar3), .tc(tc3), .co(co3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic exp_t predict(int m, int w, int cur, int co_cur,
                                     bit r, bit e, bit u, bit l, int d);
        exp_t x;
        int qn, n, mask;
        mask = (1 << w) - 1;
        qn = r ? cur : 0;
        x.qnow  = qn;
        x.conow = r ? co_cur : 0;
        x.tc    = e & ~l & (u ? (qn == m - 1) : (qn == 0));
        if (l)      n = (d < m) ? d : m - 1;
        else if (e) n = u ? (qn + 1) % m : (qn + m - 1) % m;
        else        n = qn;
        x.jexp   = n & ~qn & mask;
        x.kexp   = ~n & qn & mask;
        x.qnext  = r ? n : 0;
        x.conext = r ? int'(x.tc) : 0;
        return x;
    endfunction

    task automatic drive(input bit r, input bit e, input bit u, input bit l, input int d);
        exp_t x;
        @(negedge clk);
        #1;
        rst = r; en = e; up = u; load = l;
        din4 = d[3:0];
        din3 = d[2:0];
        x = predict(10, 4, m4q, m4co, r, e, u, l, d & 15);
        sb4.push_back(x);
        m4q = x.qnext; m4co = x.conext;
        x = predict(8, 3, m3q, m3co, r, e, u, l, d & 7);
        sb3.push_back(x);
        m3q = x.qnext; m3co = x.conext;
    endtask

    // Monitor: pre-edge checks of combinational/async state, post-edge checks of q/co.
    initial begin : monitor
        exp_t p4, p3;
        bit   have = 0;
        forever begin
            @(negedge clk);
            if (have) begin
                chk("m10 q",    q4,    p4.qnext);
                chk("m10 qbar", qbar4, (~p4.qnext) & 15);
                chk("m10 co",   co4,   p4.conext);
                chk("m8 q",     q3,    p3.qnext);
                chk("m8 qbar",  qbar3, (~p3.qnext) & 7);
                chk("m8 co",    co3,   p3.conext);
                have = 0;
            end
            #3;
            if (sb4.size() != 0 && sb3.size() != 0) begin
                p4 = sb4.pop_front();
                p3 = sb3.pop_front();
                chk("m10 tc",      tc4,        p4.tc);
                chk("m10 q_now",   q4,         p4.qnow);
                chk("m10 qbar_now", qbar4,     (~p4.qnow) & 15);
                chk("m10 co_now",  co4,        p4.conow);
                chk("m10 j",       u4.j_vec,   p4.jexp);
                chk("m10 k",       u4.k_vec,   p4.kexp);
                chk("m8 tc",       tc3,        p3.tc);
                chk("m8 q_now",    q3,         p3.qnow);
                chk("m8 co_now",   co3,        p3.conow);
                chk("m8 j",        u3.j_vec,   p3.jexp);
                chk("m8 k",        u3.k_vec,   p3.kexp);
                have = 1;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        rst = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; din4 = '0; din3 = '0;
        repeat (2) drive(0, 0, 0, 0, 0);
        repeat (12) drive(1, 1, 1, 0, 0);
        repeat (5) drive(1, 1, 1, 0, 0);
        // Reset lands between edges with the 4-bit counter at 7.
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 1, 1, 3);
        drive(1, 0, 1, 0, 0);
        drive(1, 0, 0, 1, 2);
        repeat (4) drive(1, 1, 0, 0, 0);
        drive(1, 1, 1, 1, 6);
        drive(1, 1, 0, 1, 13);
        drive(1, 1, 1, 1, 0);
        drive(1, 1, 0, 1, 9);
        drive(1, 0, 1, 1, 5);
        repeat (3) drive(1, 0, 1, 0, 0);
        drive(1, 1, 1, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 1, 0, 0);
        drive(1, 1, 0, 0, 0);
        repeat (20) drive(1, 1, 1, 0, 0);
        repeat (400) begin
            drive(($urandom_range(0, 39) != 0),
                  ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 15)));
        end
        repeat (3) @(negedge clk);
        chk("drain m10", sb4.size(), 0);
        chk("drain m8",  sb3.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
